// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: operation and state encodings,
// access-size classification and misalignment handling.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LBU = 3'd1,
        LSU_LH  = 3'd2,
        LSU_LHU = 3'd3,
        LSU_LW  = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    function automatic logic is_load(lsu_op_e op);
        return op inside {LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW};
    endfunction

    function automatic lsu_size_e access_size(lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(lsu_op_e op, logic [31:0] addr);
        case (access_size(op))
            SZ_HALF: return addr[0];
            SZ_WORD: return |addr[1:0];
            default: return 1'b0;
        endcase
    endfunction

    // Clears the low address bits that cannot be honoured for the access size.
    function automatic logic [31:0] align_addr(lsu_op_e op, logic [31:0] addr);
        case (access_size(op))
            SZ_HALF: return {addr[31:1], 1'b0};
            SZ_WORD: return {addr[31:2], 2'b00};
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: extract and extend a load from a memory word,
// and merge store data into the addressed lane of a previously read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rd_word[{offset, 3'b000} +: 8];
        half_v = rd_word[{offset[1], 4'b0000} +: 16];
        case (op)
            LSU_LB:  ld_data = {{24{byte_v[7]}}, byte_v};
            LSU_LBU: ld_data = {24'h0, byte_v};
            LSU_LH:  ld_data = {{16{half_v[15]}}, half_v};
            LSU_LHU: ld_data = {16'h0, half_v};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        st_word = old_word;
        case (access_size(op))
            SZ_BYTE: st_word[{offset, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: st_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-organised data memory; sub-word stores use read-modify-write.
// Build option: define LSU_ALIGN_EXC_EN to report misaligned half/word accesses as errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    lsu_state_e  state, state_next;
    lsu_op_e     req_op_e, op_q;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic        err_q;
    logic        req_err;
    logic [31:0] ld_data, st_word;

    assign req_op_e = lsu_op_e'(req_op);

    always_comb begin
        req_err = ({1'b0, req_addr} >= ADDR_LIMIT);
`ifdef LSU_ALIGN_EXC_EN
        req_err = req_err || is_misaligned(req_op_e, req_addr);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                 state_next = ST_RESP;
                    else if (is_load(req_op_e))  state_next = ST_LOAD;
                    else if (req_op_e == LSU_SW) state_next = ST_STORE;
                    else                         state_next = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_rd     = 1'b1;
                state_next = ST_RESP;
            end
            ST_STORE: begin
                mem_wr     = 1'b1;
                state_next = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_rd     = 1'b1;
                state_next = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_wr     = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Response registers change only on the edge into RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= LSU_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op_e;
                        addr_q  <= align_addr(req_op_e, req_addr);
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= ld_data;
                    err_q   <= 1'b0;
                end
                ST_RMW_RD: begin
                    word_q <= mem_rdata;
                end
                ST_STORE, ST_RMW_WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    lsu_lane u_lane (
        .op       (op_q),
        .offset   (addr_q[1:0]),
        .rd_word  (mem_rdata),
        .old_word (word_q),
        .wdata    (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    assign mem_addr   = (mem_rd || mem_wr) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata  = mem_wr ? st_word : '0;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
